// File: rtl/tl_burst_arbiter_if.sv
// TileLink-UL A/D channel bundle; "master" issues A and consumes D, "slave" the opposite.
// Upstream masters carry no size/mask, so the slave view leaves those out.
interface tl_burst_arbiter_if #(
   parameter int ADDRESS_WIDTH = 30,
   parameter int SOURCE_WIDTH  = 2
);
   logic                     a_valid;
   logic                     a_ready;
   logic [2:0]               a_opcode;
   logic [SOURCE_WIDTH-1:0]  a_source;
   logic [ADDRESS_WIDTH-1:0] a_address;
   logic [2:0]               a_size;
   logic [7:0]               a_mask;
   logic [63:0]              a_data;
   logic                     d_valid;
   logic                     d_ready;
   logic [2:0]               d_opcode;
   logic [SOURCE_WIDTH-1:0]  d_source;
   logic [63:0]              d_data;

   modport master (
      output a_valid, a_opcode, a_source, a_address, a_size, a_mask, a_data, d_ready,
      input  a_ready, d_valid, d_opcode, d_source, d_data
   );

   modport slave (
      input  a_valid, a_opcode, a_source, a_address, a_data, d_ready,
      output a_ready, d_valid, d_opcode, d_source, d_data
   );
endinterface

// File: rtl/tl_burst_arbiter.sv
// Two-master TileLink-UL burst arbiter feeding the DDR3 native-port adapter.
// Master identity rides in the downstream source MSB; each master is capped at MAX_OUTSTANDING messages.
module tl_burst_arbiter #(
   parameter int ADDRESS_WIDTH   = 30,
   parameter int SOURCE_WIDTH    = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   tl_burst_arbiter_if.slave    s0,
   tl_burst_arbiter_if.slave    s1,
   tl_burst_arbiter_if.master   m
);
   localparam logic [2:0] OP_GET       = 3'd4;
   localparam logic [2:0] OP_PUT_FULL  = 3'd0;
   localparam logic [2:0] OP_ACK_DATA  = 3'd1;
   localparam logic [2:0] MAX_CNT      = 3'(MAX_OUTSTANDING);

   typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

   state_t                   state_reg, state_next;
   logic                     grant_reg, rr_reg;
   logic [2:0]               a_beat_reg;
   logic                     lock;

   logic [1:0]               s_a_valid, s_d_ready, eligible, d_valid_s;
   logic [2:0]               s_a_opcode  [2];
   logic [SOURCE_WIDTH-1:0]  s_a_source  [2];
   logic [ADDRESS_WIDTH-1:0] s_a_address [2];
   logic [63:0]              s_a_data    [2];
   logic [2:0]               out_cnt     [2];

   logic                     grant, a_valid, is_put, a_last, a_fire, a_done;
   logic [2:0]               a_opcode;
   logic [SOURCE_WIDTH-1:0]  a_source;
   logic [ADDRESS_WIDTH-1:0] a_address;
   logic [63:0]              a_data;
   logic                     d_sel, d_is_data;

   assign s_a_valid      = {s1.a_valid, s0.a_valid};
   assign s_d_ready      = {s1.d_ready, s0.d_ready};
   assign s_a_opcode[0]  = s0.a_opcode;
   assign s_a_opcode[1]  = s1.a_opcode;
   assign s_a_source[0]  = s0.a_source;
   assign s_a_source[1]  = s1.a_source;
   assign s_a_address[0] = s0.a_address;
   assign s_a_address[1] = s1.a_address;
   assign s_a_data[0]    = s0.a_data;
   assign s_a_data[1]    = s1.a_data;

   assign lock = (state_reg == ST_LOCKED);

   // Grant FSM: OPEN picks a master each cycle, LOCKED pins the grant until the message fires.
   always_comb begin
      state_next = state_reg;
      grant      = grant_reg;
      a_valid    = 1'b0;
      case (state_reg)
         ST_OPEN: begin
            if (&eligible)
               grant = rr_reg;
            else
               grant = eligible[1];
            a_valid = |eligible;
         end
         ST_LOCKED: a_valid = s_a_valid[grant_reg];
         default:   a_valid = 1'b0;
      endcase
      a_valid   = a_valid & ~reset;
      a_opcode  = s_a_opcode[grant];
      a_source  = s_a_source[grant];
      a_address = s_a_address[grant];
      a_data    = s_a_data[grant];
      is_put    = (a_opcode == OP_PUT_FULL);
      a_last    = ~is_put | (a_beat_reg == 3'd7);
      a_fire    = a_valid & m.a_ready;
      a_done    = a_fire & a_last;
      if (a_fire)
         state_next = a_last ? ST_OPEN : ST_LOCKED;
      else if (a_valid)
         state_next = ST_LOCKED;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= ST_OPEN;
         grant_reg  <= 1'b0;
         rr_reg     <= 1'b0;
         a_beat_reg <= 3'd0;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant;
         if (a_fire && is_put)
            a_beat_reg <= a_beat_reg + 3'd1;
         if (a_done)
            rr_reg <= ~grant;
      end
   end

   assign m.a_valid   = a_valid;
   assign m.a_opcode  = a_opcode;
   assign m.a_source  = {grant, a_source};
   assign m.a_address = a_address;
   assign m.a_size    = 3'd6;
   assign m.a_mask    = 8'hFF;
   assign m.a_data    = a_data;
   assign s0.a_ready  = m.a_ready & a_valid & (grant == 1'b0);
   assign s1.a_ready  = m.a_ready & a_valid & (grant == 1'b1);

   assign d_sel      = m.d_source[SOURCE_WIDTH];
   assign d_is_data  = (m.d_opcode == OP_ACK_DATA);
   assign m.d_ready  = ~reset & s_d_ready[d_sel];

   assign s0.d_valid  = d_valid_s[0];
   assign s1.d_valid  = d_valid_s[1];
   assign s0.d_opcode = m.d_opcode;
   assign s1.d_opcode = m.d_opcode;
   assign s0.d_source = m.d_source[SOURCE_WIDTH-1:0];
   assign s1.d_source = m.d_source[SOURCE_WIDTH-1:0];
   assign s0.d_data   = m.d_data;
   assign s1.d_data   = m.d_data;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_master
         logic [2:0] out_cnt_reg, d_beat_reg;
         logic       d_fire, d_done, a_inc;

         assign d_valid_s[gi] = ~reset & m.d_valid & (d_sel == 1'(gi));
         assign d_fire        = d_valid_s[gi] & s_d_ready[gi];
         assign d_done        = d_fire & (~d_is_data | (d_beat_reg == 3'd7));
         assign a_inc         = a_done & (grant == 1'(gi));
         // A master already inside a burst must be allowed to finish it.
         assign eligible[gi]  = s_a_valid[gi] & ((out_cnt_reg < MAX_CNT) | (a_beat_reg != 3'd0));
         assign out_cnt[gi]   = out_cnt_reg;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               out_cnt_reg <= 3'd0;
               d_beat_reg  <= 3'd0;
            end else begin
               if (d_fire && d_is_data)
                  d_beat_reg <= d_beat_reg + 3'd1;
               case ({a_inc, d_done})
                  2'b10:   out_cnt_reg <= out_cnt_reg + 3'd1;
                  2'b01:   if (out_cnt_reg != 3'd0) out_cnt_reg <= out_cnt_reg - 3'd1;
                  default: out_cnt_reg <= out_cnt_reg;
               endcase
            end
         end
      end
   endgenerate

   logic unused_get;
   assign unused_get = (a_opcode == OP_GET);
endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Directed bench for tl_burst_arbiter: grant ordering, burst locking, throttling and reset.
module tb_tl_burst_arbiter;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tl_burst_arbiter_if #(.ADDRESS_WIDTH(30), .SOURCE_WIDTH(2)) s0 ();
   tl_burst_arbiter_if #(.ADDRESS_WIDTH(30), .SOURCE_WIDTH(2)) s1 ();
   tl_burst_arbiter_if #(.ADDRESS_WIDTH(30), .SOURCE_WIDTH(3)) m ();

   tl_burst_arbiter #(.ADDRESS_WIDTH(30), .SOURCE_WIDTH(2), .MAX_OUTSTANDING(4)) dut (
      .clk   (clk),
      .reset (reset),
      .s0    (s0),
      .s1    (s1),
      .m     (m)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      s0.a_valid = 0; s0.a_opcode = 3'd4; s0.a_source = 0; s0.a_address = 0; s0.a_data = 0;
      s1.a_valid = 0; s1.a_opcode = 3'd4; s1.a_source = 0; s1.a_address = 0; s1.a_data = 0;
      s0.a_size = 3'd6; s0.a_mask = 8'hFF; s1.a_size = 3'd6; s1.a_mask = 8'hFF;
      s0.d_ready = 1; s1.d_ready = 1;
      m.a_ready = 1; m.d_valid = 0; m.d_opcode = 0; m.d_source = 0; m.d_data = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      idle();
      tick();
      tick();
      reset = 0;
      #1;
   endtask

   logic [2:0] alt_src [4] = '{3'b000, 3'b110, 3'b000, 3'b110};

   initial begin
      // Reset: outputs quiet even with live inputs
      reset = 1;
      idle();
      s0.a_valid = 1;
      m.d_valid = 1;
      #2;
      chk("rst_m_a_valid", m.a_valid, 0);
      chk("rst_s0_a_ready", s0.a_ready, 0);
      chk("rst_s0_d_valid", s0.d_valid, 0);
      chk("rst_m_d_ready", m.d_ready, 0);
      do_reset();

      // Single Get from s0 and its 8-beat ReadData
      s0.a_valid = 1; s0.a_opcode = 3'd4; s0.a_source = 2'd1; s0.a_address = 30'h100;
      #1;
      chk("get_m_a_valid", m.a_valid, 1);
      chk("get_m_a_source", m.a_source, 3'b001);
      chk("get_m_a_address", m.a_address, 64'h100);
      chk("get_m_a_size", m.a_size, 6);
      chk("get_m_a_mask", m.a_mask, 8'hFF);
      chk("get_s0_a_ready", s0.a_ready, 1);
      chk("get_s1_a_ready", s1.a_ready, 0);
      tick();
      $display("txn: s0 Get addr=0x100 src=1");
      s0.a_valid = 0;
      #1;
      chk("get_lock", dut.lock, 0);
      chk("get_out_cnt0", dut.out_cnt[0], 1);
      for (int i = 0; i < 8; i++) begin
         m.d_valid = 1; m.d_opcode = 3'd1; m.d_source = 3'b001; m.d_data = 64'hA000 + 64'(i);
         #1;
         chk("rd_s0_d_valid", s0.d_valid, 1);
         chk("rd_s1_d_valid", s1.d_valid, 0);
         chk("rd_s0_d_data", s0.d_data, 64'hA000 + 64'(i));
         chk("rd_s0_d_source", s0.d_source, 1);
         chk("rd_m_d_ready", m.d_ready, 1);
         tick();
         if (i == 6) chk("rd_out_cnt0_mid", dut.out_cnt[0], 1);
      end
      m.d_valid = 0;
      chk("rd_out_cnt0_done", dut.out_cnt[0], 0);
      $display("txn: s0 ReadData 8 beats");

      // Simultaneous Gets alternate starting from master 0
      do_reset();
      s0.a_valid = 1; s0.a_opcode = 3'd4; s0.a_source = 2'd0;
      s1.a_valid = 1; s1.a_opcode = 3'd4; s1.a_source = 2'd2;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_m_a_source", m.a_source, 64'(alt_src[i]));
         chk("rr_s0_a_ready", s0.a_ready, (i % 2 == 0) ? 1 : 0);
         chk("rr_s1_a_ready", s1.a_ready, (i % 2 == 1) ? 1 : 0);
         tick();
         $display("txn: rr Get %0d granted src=%03b", i, alt_src[i]);
      end

      // PutFull burst from s0 with toggling ready while s1 waits with a Get
      do_reset();
      s0.a_valid = 1; s0.a_opcode = 3'd0; s0.a_source = 2'd2; s0.a_address = 30'h40;
      s1.a_valid = 1; s1.a_opcode = 3'd4; s1.a_source = 2'd1; s1.a_address = 30'h80;
      for (int c = 0; c < 16; c++) begin
         m.a_ready = c[0];
         s0.a_data = 64'hD0 + 64'(c / 2);
         #1;
         chk("put_m_a_source", m.a_source, 3'b010);
         chk("put_m_a_data", m.a_data, 64'hD0 + 64'(c / 2));
         chk("put_s0_a_ready", s0.a_ready, c[0]);
         chk("put_s1_a_ready", s1.a_ready, 0);
         tick();
         if (c[0]) $display("txn: s0 PutFull beat %0d", c / 2);
      end
      s0.a_valid = 0;
      m.a_ready = 1;
      #1;
      chk("put_s1_after_src", m.a_source, 3'b101);
      chk("put_s1_after_op", m.a_opcode, 3'd4);
      chk("put_s1_after_ready", s1.a_ready, 1);
      chk("put_a_beat_wrap", dut.a_beat_reg, 0);
      tick();
      $display("txn: s1 Get after burst");
      s1.a_valid = 0;

      // Stalled Get keeps its grant when another master rises
      do_reset();
      m.a_ready = 0;
      s0.a_valid = 1; s0.a_opcode = 3'd4; s0.a_source = 2'd3;
      #1;
      chk("hold_src0", m.a_source, 3'b011);
      tick();
      s1.a_valid = 1; s1.a_opcode = 3'd4; s1.a_source = 2'd0;
      #1;
      chk("hold_src1", m.a_source, 3'b011);
      chk("hold_s1_ready", s1.a_ready, 0);
      tick();
      chk("hold_src2", m.a_source, 3'b011);
      m.a_ready = 1;
      #1;
      chk("hold_s0_fire", s0.a_ready, 1);
      tick();
      $display("txn: s0 Get after stall");
      s0.a_valid = 0;
      #1;
      chk("hold_s1_src", m.a_source, 3'b100);
      chk("hold_s1_fire", s1.a_ready, 1);
      tick();
      $display("txn: s1 Get after stall");
      s1.a_valid = 0;

      // Outstanding limit throttles s1 but not s0
      do_reset();
      s1.a_valid = 1; s1.a_opcode = 3'd4; s1.a_source = 2'd2; s1.a_address = 30'h200;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("lim_s1_ready", s1.a_ready, 1);
         tick();
         $display("txn: s1 Get %0d", i);
      end
      chk("lim_s1_stall", s1.a_ready, 0);
      chk("lim_m_a_valid", m.a_valid, 0);
      s0.a_valid = 1; s0.a_opcode = 3'd4; s0.a_source = 2'd1;
      #1;
      chk("lim_s0_valid", m.a_valid, 1);
      chk("lim_s0_src", m.a_source, 3'b001);
      chk("lim_s0_ready", s0.a_ready, 1);
      chk("lim_s1_ready2", s1.a_ready, 0);
      tick();
      $display("txn: s0 Get past throttled s1");
      s0.a_valid = 0;
      for (int i = 0; i < 8; i++) begin
         m.d_valid = 1; m.d_opcode = 3'd1; m.d_source = 3'b110; m.d_data = 64'hB0 + 64'(i);
         #1;
         chk("lim_s1_d_valid", s1.d_valid, 1);
         chk("lim_s0_d_valid", s0.d_valid, 0);
         chk("lim_s1_still", s1.a_ready, 0);
         tick();
      end
      m.d_valid = 0;
      $display("txn: s1 ReadData 8 beats");
      #1;
      chk("lim_out_cnt1", dut.out_cnt[1], 3);
      chk("lim_s1_resume", s1.a_ready, 1);
      chk("lim_s1_src", m.a_source, 3'b110);
      tick();
      $display("txn: s1 fifth Get");
      s1.a_valid = 0;

      // Reset in the middle of a burst
      do_reset();
      s0.a_valid = 1; s0.a_opcode = 3'd0; s0.a_source = 2'd0; s0.a_address = 30'h300;
      for (int i = 0; i < 3; i++) begin
         s0.a_data = 64'hE0 + 64'(i);
         #1;
         chk("mid_m_a_data", m.a_data, 64'hE0 + 64'(i));
         tick();
         $display("txn: s0 PutFull beat %0d", i);
      end
      chk("mid_a_beat", dut.a_beat_reg, 3);
      reset = 1;
      #1;
      chk("mid_rst_m_a_valid", m.a_valid, 0);
      chk("mid_rst_s0_ready", s0.a_ready, 0);
      chk("mid_rst_a_beat", dut.a_beat_reg, 0);
      chk("mid_rst_lock", dut.lock, 0);
      tick();
      s0.a_valid = 0;
      reset = 0;
      s1.a_valid = 1; s1.a_opcode = 3'd4; s1.a_source = 2'd1;
      #1;
      chk("post_m_a_valid", m.a_valid, 1);
      chk("post_m_a_source", m.a_source, 3'b101);
      chk("post_s1_ready", s1.a_ready, 1);
      chk("post_a_beat", dut.a_beat_reg, 0);
      tick();
      $display("txn: s1 Get after reset");
      s1.a_valid = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tl_burst_arbiter.md
Name: tl_burst_arbiter

Overview:
Two-master TileLink-UL arbiter placed directly upstream of the DDR3 native-port adapter. It merges two cached masters (CPU data cache, video/DMA fetcher) onto the single 64-bit A/D channel pair that the adapter consumes. The A channel is burst-aware: Get is 1 beat, PutFull is 8 beats, size is always 6. Master identity is tagged into the source MSB, D responses are routed back on that bit, and a per-master outstanding-message limit is enforced.

Parameters:
ADDRESS_WIDTH, 30, byte address width on all A channels
SOURCE_WIDTH, 2, per-master source width; downstream source is SOURCE_WIDTH+1 bits
MAX_OUTSTANDING, 4, max accepted-but-unanswered messages per master (1..7)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
sN_a_valid  in  1  master N (N=0,1) A valid
sN_a_ready  out  1  master N A ready
sN_a_opcode  in  3  4=Get, 0=PutFull
sN_a_source  in  SOURCE_WIDTH  master N source
sN_a_address  in  ADDRESS_WIDTH  64-byte-aligned address
sN_a_data  in  64  write beat data
sN_d_valid  out  1  master N D valid
sN_d_ready  in  1  master N D ready
sN_d_opcode  out  3  0=WriteAck, 1=ReadData
sN_d_source  out  SOURCE_WIDTH  m_d_source without MSB
sN_d_data  out  64  read beat data
m_a_valid  out  1  downstream A valid
m_a_ready  in  1  downstream A ready
m_a_opcode  out  3  forwarded opcode
m_a_source  out  SOURCE_WIDTH+1  {grant, sN_a_source}
m_a_address  out  ADDRESS_WIDTH  forwarded address
m_a_size  out  3  constant 6
m_a_mask  out  8  constant 8'hFF
m_a_data  out  64  forwarded data
m_d_valid  in  1  downstream D valid
m_d_ready  out  1  downstream D ready
m_d_opcode  in  3  D opcode
m_d_source  in  SOURCE_WIDTH+1  D source; MSB selects master
m_d_data  in  64  D data

Behaviour:
- State: grant (1b), lock (1b), rr (1b, next-priority master), a_beat (3b), per master out_cnt (3b) and d_beat (3b). Reset value of all state is 0. While reset is high, all *_valid and *_ready outputs are 0.
- eligible_N = sN_a_valid & (out_cnt_N < MAX_OUTSTANDING | a_beat != 0). A master in mid-burst is never throttled.
- Grant selection when lock=0: if both masters are eligible, grant = rr; if one is eligible, grant = that master; if none, m_a_valid = 0.
- When lock=1, grant is held. m_a_valid = sN_a_valid of the granted master. The limit check does not apply while locked.
- m_a_* is the granted master's fields, muxed combinationally with zero added latency. sN_a_ready = m_a_ready & (grant==N) & m_a_valid. The non-granted master sees ready 0.
- Lock set: at a clock edge where m_a_valid & ~m_a_ready, so a presented request cannot switch masters before it fires. Also set on a PutFull fire with a_beat != 7.
- Lock clear: on a Get fire, or on a PutFull fire with a_beat==7.
- a_beat increments on each PutFull fire and wraps 7->0. Get does not touch a_beat.
- On message completion (Get fire, or PutFull beat 7 fire): rr <= ~grant, and out_cnt[grant] increments.
- D routing is combinational. sN_d_valid = m_d_valid & (m_d_source MSB == N). m_d_ready = selected master's sN_d_ready. The opcode, data and low source bits go to both masters unchanged.
- D completion for master N on each D fire: a WriteAck completes immediately. ReadData increments d_beat_N and completes on beat 7 (d_beat wraps to 0).
- On D completion, out_cnt_N decrements. If an A completion and a D completion for the same master land in the same cycle, out_cnt_N is unchanged.
- out_cnt never under- or overflows in legal traffic. A D completion with out_cnt=0 is a protocol error and holds out_cnt at 0.
- A PutFull fragment whose opcode changes mid-burst is illegal and is not checked.
- Asserting reset mid-burst clears lock, a_beat and counters. The downstream adapter must be reset together with this block.

Test Plan:
- Single Get from s0, address 0x100, source 1 → m_a_source=3'b001, one beat, lock stays 0. Eight ReadData beats with m_d_source=3'b001 → only s0_d_valid asserts; s0 out_cnt returns 0→1→0.
- Both masters assert Get in the same cycle with rr=0 → s0 granted first, s1 on the next fire; repeated 4 times the grants alternate 0,1,0,1.
- s0 sends a PutFull (8 beats, m_a_ready toggling every other cycle) while s1 holds a Get → all 8 s0 beats are contiguous on m_a, s1 fires after beat 7, and m_a_source MSB never changes mid-burst.
- With m_a_ready=0, s0 presents a Get and s1 rises next cycle → grant stays 0 until the fire.
- s1 issues 4 Gets with no D responses (MAX_OUTSTANDING=4) → 5th Get is stalled (s1_a_ready=0) while s0 traffic still passes. One completed ReadData (8 beats) to s1 → 5th Get fires.
- Reset asserted mid-PutFull at a_beat=3 → m_a_valid=0 during reset. After release, a new s1 Get is granted immediately with a_beat=0.
